regfile_port_arbiter: RTL and testbench
=======================================

# regfile_port_arbiter

Shares the write port and the read port of the 8×32 register file between two requesters (req0, req1) using a valid/ready handshake. It sits directly in front of the register file and drives its `we`/`wAddr`/`wData`/`rAddr` inputs. Each port is arbitrated independently with round-robin priority, and read data is returned one cycle after grant on a registered response channel. The block lets a load/store sequencer and a host/debug interface share one register file without corrupting each other's accesses.

## Interface
- `DATA_W`, 32, data width of register-file words
- `ADDR_W`, 3, register-file address width (8 entries)

Ports:
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous active-low reset
- `reqN_valid`  in  1  requester N (N=0,1) has a request pending
- `reqN_we`  in  1  1 = write, 0 = read
- `reqN_addr`  in  ADDR_W  target register
- `reqN_wdata`  in  DATA_W  write data; ignored for reads
- `reqN_ready`  out  1  request accepted this cycle (combinational grant)
- `rspN_valid`  out  1  one-cycle pulse: read data valid on `rspN_data`
- `rspN_data`  out  DATA_W  registered read data
- `rf_we`  out  1  register-file write enable
- `rf_wAddr`  out  ADDR_W  register-file write address
- `rf_wData`  out  DATA_W  register-file write data
- `rf_rAddr`  out  ADDR_W  register-file read address
- `rf_rData`  in  DATA_W  register-file read data (combinational from `rf_rAddr`)

## Operation
- A request transfers on a cycle where `valid && ready`. A requester holds `valid`, `we`, `addr` and `wdata` stable until `ready` is high. The arbiter never deasserts `ready` for an accepted beat.
- Write port:
  - Candidates are the requesters with `valid && we`.
  - One candidate: it is granted.
  - Two candidates: `wr_prio` selects the winner (0 → req0, 1 → req1). After such a conflict, `wr_prio` flips to point to the loser.
  - `wr_prio` changes only on a conflict.
- Read port: same rule for `valid && !we` candidates, using an independent `rd_prio`.
- One write and one read from different requesters are both granted in the same cycle.
- A requester never has more than one beat granted per cycle.
- `rf_we` = write grant. `rf_wAddr`/`rf_wData` come from the write winner. With no write winner they hold 0.
- `rf_rAddr` comes from the read winner; it is 0 when there is no read winner.
- `rf_rData` is sampled at the grant edge into `rspN_data`, and `rspN_valid` pulses for the winner in the next cycle.
- `rspN_data` holds its value until the next read response to N.
- Read and write to the same address in the same cycle: the read returns the old contents. The register file updates at that edge, so no bypass is performed.
- There is no response backpressure. A requester must accept `rspN_valid` whenever it occurs.

## Timing
- Grant and `rf_*` outputs are combinational from the `req*` inputs in the same cycle. The write is committed at the next rising edge.
- Read latency is 1 cycle: grant in cycle T, `rspN_valid`/`rspN_data` in cycle T+1.
- Back-to-back reads by one requester give a response every cycle.
- Under continuous contention on one port, each requester is granted every other cycle. Worst-case wait is 1 cycle.
- Reset (`reset_n` low, asynchronous):
  - `wr_prio`=0, `rd_prio`=0, `rsp0_valid`=`rsp1_valid`=0, `rsp0_data`=`rsp1_data`=0.
  - `req*_ready` and `rf_we` are forced to 0 while `reset_n` is low.
- Reset asserted in the cycle after a read grant: the pending response is dropped and `rspN_valid` stays 0.
- After deassertion, the first edge with `reset_n` high is a normal cycle.

## Structure
- Shared package holds `DATA_W`, `ADDR_W`, and an op constant (`OP_READ`=0, `OP_WRITE`=1).
- Sub-module `rr_arb2`:
  - Two request inputs, two one-hot grant outputs, its own priority flop, plus `clk` and `reset_n`.
  - Instantiated twice, once for the write port and once for the read port.
- The top level contains the candidate decode, the `rf_*` muxing and the response registers.

## Test plan
- Reset, then req0 writes `0xDEADBEEF` to r3 and later reads r3. Required: `req0_ready`=1 on both requests, `rf_we`=1 for exactly one cycle, `rsp0_valid` one cycle after the read grant with `rsp0_data`=`0xDEADBEEF`.
- Both requesters write at once (req0 → r1 `0x11`, req1 → r2 `0x22`), held valid. Required: req0 granted first (prio reset 0), req1 granted next cycle, and both registers hold their values afterwards.
- req0 writes r5 `0x55` while req1 reads r5 in the same cycle, with r5 previously `0xA5`. Required: both granted that cycle, `rsp1_data`=`0xA5`, and a later read returns `0x55`.
- Both requesters issue continuous reads for 6 cycles. Required: grants alternate 0,1,0,1,0,1 and responses alternate accordingly, each with 1-cycle latency.
- req1 reads r7 and `reset_n` is asserted in the following cycle. Required: `rsp1_valid` stays 0, `rsp1_data`=0, `ready` stays 0 during reset, and prio returns to 0.

Source files
------------

// File: rtl/regfile_port_arbiter_pkg.sv
// Shared widths and op encoding for the register-file port arbiter.
package regfile_port_arbiter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 3;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/regfile_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, priority flips to the loser on conflict.
module rr_arb2 (
  input  logic clk,
  input  logic reset_n,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  logic prio_q;
  logic prio_d;
  logic conflict;

  assign conflict = req0_i & req1_i;

  // Grant decode; priority only decides when both request.
  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    prio_d = prio_q;
    if (conflict) begin
      gnt0_o = ~prio_q;
      gnt1_o = prio_q;
      prio_d = ~prio_q;
    end else begin
      gnt0_o = req0_i;
      gnt1_o = req1_i;
    end
  end

  // Priority pointer, moves only on a conflict.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the register-file write and read ports between two requesters.
module regfile_port_arbiter
  import regfile_port_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wAddr,
  output logic [DATA_W-1:0] rf_wData,
  output logic [ADDR_W-1:0] rf_rAddr,
  input  logic [DATA_W-1:0] rf_rData
);

  logic wr_cand0, wr_cand1, rd_cand0, rd_cand1;
  logic wr_gnt0, wr_gnt1, rd_gnt0, rd_gnt1;
  logic wr_win0, wr_win1, rd_win0, rd_win1;

  logic              rsp0_valid_q, rsp1_valid_q;
  logic [DATA_W-1:0] rsp0_data_q,  rsp1_data_q;
  logic [DATA_W-1:0] rsp0_data_d,  rsp1_data_d;

  assign wr_cand0 = req0_valid & (req0_we == OP_WRITE);
  assign wr_cand1 = req1_valid & (req1_we == OP_WRITE);
  assign rd_cand0 = req0_valid & (req0_we == OP_READ);
  assign rd_cand1 = req1_valid & (req1_we == OP_READ);

  rr_arb2 u_wr_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req0_i  (wr_cand0),
    .req1_i  (wr_cand1),
    .gnt0_o  (wr_gnt0),
    .gnt1_o  (wr_gnt1)
  );

  rr_arb2 u_rd_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req0_i  (rd_cand0),
    .req1_i  (rd_cand1),
    .gnt0_o  (rd_gnt0),
    .gnt1_o  (rd_gnt1)
  );

  // No grant may be issued while reset is held.
  assign wr_win0 = wr_gnt0 & reset_n;
  assign wr_win1 = wr_gnt1 & reset_n;
  assign rd_win0 = rd_gnt0 & reset_n;
  assign rd_win1 = rd_gnt1 & reset_n;

  // Handshake and register-file port muxing from the winners.
  always_comb begin
    req0_ready = wr_win0 | rd_win0;
    req1_ready = wr_win1 | rd_win1;
    rf_we      = wr_win0 | wr_win1;
    rf_wAddr   = '0;
    rf_wData   = '0;
    rf_rAddr   = '0;
    if (wr_win0) begin
      rf_wAddr = req0_addr;
      rf_wData = req0_wdata;
    end else if (wr_win1) begin
      rf_wAddr = req1_addr;
      rf_wData = req1_wdata;
    end
    if (rd_win0) begin
      rf_rAddr = req0_addr;
    end else if (rd_win1) begin
      rf_rAddr = req1_addr;
    end
  end

  // Read data is captured only for the read winner; otherwise held.
  always_comb begin
    rsp0_data_d = rsp0_data_q;
    rsp1_data_d = rsp1_data_q;
    if (rd_win0) rsp0_data_d = rf_rData;
    if (rd_win1) rsp1_data_d = rf_rData;
  end

  // Registered response channel, one cycle after the read grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      rsp0_valid_q <= rd_win0;
      rsp1_valid_q <= rd_win1;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a behavioural 8x32 register file.
module tb_regfile_port_arbiter;

  logic        clk;
  logic        reset_n;
  logic        req0_valid, req0_we, req0_ready;
  logic [2:0]  req0_addr;
  logic [31:0] req0_wdata;
  logic        req1_valid, req1_we, req1_ready;
  logic [2:0]  req1_addr;
  logic [31:0] req1_wdata;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_data, rsp1_data;
  logic        rf_we;
  logic [2:0]  rf_wAddr, rf_rAddr;
  logic [31:0] rf_wData, rf_rData;

  logic [31:0] rf_mem [8];

  int n_checks;
  int n_errors;

  regfile_port_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_ready (req1_ready),
    .rsp0_valid (rsp0_valid),
    .rsp0_data  (rsp0_data),
    .rsp1_valid (rsp1_valid),
    .rsp1_data  (rsp1_data),
    .rf_we      (rf_we),
    .rf_wAddr   (rf_wAddr),
    .rf_wData   (rf_wData),
    .rf_rAddr   (rf_rAddr),
    .rf_rData   (rf_rData)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file: combinational read, write at the rising edge.
  initial begin
    for (int i = 0; i < 8; i++) rf_mem[i] = '0;
  end
  always @(posedge clk) if (rf_we) rf_mem[rf_wAddr] <= rf_wData;
  assign rf_rData = rf_mem[rf_rAddr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic we, input logic [2:0] a, input logic [31:0] d);
    req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
  endtask

  task automatic set1(input logic v, input logic we, input logic [2:0] a, input logic [31:0] d);
    req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    set0(1'b0, 1'b0, 3'd0, 32'h0);
    set1(1'b0, 1'b0, 3'd0, 32'h0);

    // Reset state, and no grants while reset is low.
    @(negedge clk);
    check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("rst_rsp0_data", rsp0_data, 32'h0);
    check("rst_rsp1_data", rsp1_data, 32'h0);
    set0(1'b1, 1'b1, 3'd2, 32'h1234);
    set1(1'b1, 1'b0, 3'd2, 32'h0);
    #1;
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_ready1", 32'(req1_ready), 32'd0);
    check("rst_rf_we", 32'(rf_we), 32'd0);
    set0(1'b0, 1'b0, 3'd0, 32'h0);
    set1(1'b0, 1'b0, 3'd0, 32'h0);
    cyc();
    reset_n = 1'b1;

    // Single write then read of r3 by req0.
    set0(1'b1, 1'b1, 3'd3, 32'hDEADBEEF);
    @(negedge clk);
    check("t1_wr_ready0", 32'(req0_ready), 32'd1);
    check("t1_rf_we", 32'(rf_we), 32'd1);
    check("t1_wAddr", 32'(rf_wAddr), 32'd3);
    check("t1_wData", rf_wData, 32'hDEADBEEF);
    cyc();
    set0(1'b0, 1'b0, 3'd0, 32'h0);
    @(negedge clk);
    check("t1_rf_we_off", 32'(rf_we), 32'd0);
    check("t1_wAddr_idle", 32'(rf_wAddr), 32'd0);
    cyc();
    set0(1'b1, 1'b0, 3'd3, 32'h0);
    @(negedge clk);
    check("t1_rd_ready0", 32'(req0_ready), 32'd1);
    check("t1_rAddr", 32'(rf_rAddr), 32'd3);
    check("t1_rsp0_early", 32'(rsp0_valid), 32'd0);
    cyc();
    set0(1'b0, 1'b0, 3'd0, 32'h0);
    @(negedge clk);
    check("t1_rsp0_valid", 32'(rsp0_valid), 32'd1);
    check("t1_rsp0_data", rsp0_data, 32'hDEADBEEF);
    check("t1_rAddr_idle", 32'(rf_rAddr), 32'd0);
    cyc();
    @(negedge clk);
    check("t1_rsp0_pulse", 32'(rsp0_valid), 32'd0);
    check("t1_rsp0_hold", rsp0_data, 32'hDEADBEEF);

    // Write conflict: req0 first, req1 next cycle.
    cyc();
    set0(1'b1, 1'b1, 3'd1, 32'h11);
    set1(1'b1, 1'b1, 3'd2, 32'h22);
    @(negedge clk);
    check("t2_ready0", 32'(req0_ready), 32'd1);
    check("t2_ready1", 32'(req1_ready), 32'd0);
    check("t2_wAddr0", 32'(rf_wAddr), 32'd1);
    check("t2_wData0", rf_wData, 32'h11);
    cyc();
    set0(1'b0, 1'b0, 3'd0, 32'h0);
    @(negedge clk);
    check("t2_ready1_next", 32'(req1_ready), 32'd1);
    check("t2_wAddr1", 32'(rf_wAddr), 32'd2);
    check("t2_wData1", rf_wData, 32'h22);
    cyc();
    set1(1'b0, 1'b0, 3'd0, 32'h0);
    set0(1'b1, 1'b0, 3'd1, 32'h0);
    @(negedge clk);
    check("t2_rd_r1_ready", 32'(req0_ready), 32'd1);
    cyc();
    set0(1'b0, 1'b0, 3'd0, 32'h0);
    set1(1'b1, 1'b0, 3'd2, 32'h0);
    @(negedge clk);
    check("t2_r1_valid", 32'(rsp0_valid), 32'd1);
    check("t2_r1_data", rsp0_data, 32'h11);
    check("t2_rd_r2_ready", 32'(req1_ready), 32'd1);
    cyc();
    set1(1'b0, 1'b0, 3'd0, 32'h0);
    @(negedge clk);
    check("t2_r2_valid", 32'(rsp1_valid), 32'd1);
    check("t2_r2_data", rsp1_data, 32'h22);

    // Same-cycle write and read of r5: read sees old contents.
    cyc();
    set1(1'b1, 1'b1, 3'd5, 32'hA5);
    @(negedge clk);
    check("t3_pre_ready1", 32'(req1_ready), 32'd1);
    cyc();
    set0(1'b1, 1'b1, 3'd5, 32'h55);
    set1(1'b1, 1'b0, 3'd5, 32'h0);
    @(negedge clk);
    check("t3_ready0", 32'(req0_ready), 32'd1);
    check("t3_ready1", 32'(req1_ready), 32'd1);
    check("t3_rf_we", 32'(rf_we), 32'd1);
    check("t3_wAddr", 32'(rf_wAddr), 32'd5);
    check("t3_rAddr", 32'(rf_rAddr), 32'd5);
    cyc();
    set0(1'b0, 1'b0, 3'd0, 32'h0);
    set1(1'b0, 1'b0, 3'd0, 32'h0);
    @(negedge clk);
    check("t3_rsp1_valid", 32'(rsp1_valid), 32'd1);
    check("t3_rsp1_old", rsp1_data, 32'hA5);
    cyc();
    set1(1'b1, 1'b0, 3'd5, 32'h0);
    cyc();
    set1(1'b0, 1'b0, 3'd0, 32'h0);
    @(negedge clk);
    check("t3_rsp1_new_valid", 32'(rsp1_valid), 32'd1);
    check("t3_rsp1_new", rsp1_data, 32'h55);

    // Write priority now points at req1 after the earlier conflict.
    cyc();
    set0(1'b1, 1'b1, 3'd6, 32'h66);
    set1(1'b1, 1'b1, 3'd4, 32'h44);
    @(negedge clk);
    check("wp_ready1", 32'(req1_ready), 32'd1);
    check("wp_ready0", 32'(req0_ready), 32'd0);
    check("wp_wAddr", 32'(rf_wAddr), 32'd4);
    cyc();
    set1(1'b0, 1'b0, 3'd0, 32'h0);
    @(negedge clk);
    check("wp_ready0_next", 32'(req0_ready), 32'd1);
    check("wp_wAddr_next", 32'(rf_wAddr), 32'd6);
    cyc();
    set0(1'b1, 1'b1, 3'd7, 32'h77);
    @(negedge clk);
    check("wp_r7_ready0", 32'(req0_ready), 32'd1);
    cyc();
    set0(1'b0, 1'b0, 3'd0, 32'h0);

    // Continuous read contention: grants alternate 0,1,0,1,0,1.
    for (int i = 0; i < 6; i++) begin
      cyc();
      set0(1'b1, 1'b0, 3'd1, 32'h0);
      set1(1'b1, 1'b0, 3'd2, 32'h0);
      @(negedge clk);
      check($sformatf("t4_ready0_%0d", i), 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("t4_ready1_%0d", i), 32'(req1_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
      check($sformatf("t4_rAddr_%0d", i), 32'(rf_rAddr), (i % 2 == 0) ? 32'd1 : 32'd2);
      if (i > 0) begin
        check($sformatf("t4_rsp0v_%0d", i), 32'(rsp0_valid), (i % 2 == 1) ? 32'd1 : 32'd0);
        check($sformatf("t4_rsp1v_%0d", i), 32'(rsp1_valid), (i % 2 == 0) ? 32'd1 : 32'd0);
        if (i % 2 == 1) check($sformatf("t4_rsp0d_%0d", i), rsp0_data, 32'h11);
        else            check($sformatf("t4_rsp1d_%0d", i), rsp1_data, 32'h22);
      end
    end
    cyc();
    set0(1'b0, 1'b0, 3'd0, 32'h0);
    set1(1'b0, 1'b0, 3'd0, 32'h0);
    @(negedge clk);
    check("t4_last_rsp1v", 32'(rsp1_valid), 32'd1);
    check("t4_last_rsp1d", rsp1_data, 32'h22);
    check("t4_last_rsp0v", 32'(rsp0_valid), 32'd0);

    // Read priority moved to req1, then req1 reads r7 and reset hits next cycle.
    cyc();
    set0(1'b1, 1'b0, 3'd1, 32'h0);
    set1(1'b1, 1'b0, 3'd7, 32'h0);
    @(negedge clk);
    check("t5_ready0", 32'(req0_ready), 32'd1);
    check("t5_ready1_wait", 32'(req1_ready), 32'd0);
    cyc();
    set0(1'b0, 1'b0, 3'd0, 32'h0);
    @(negedge clk);
    check("t5_ready1", 32'(req1_ready), 32'd1);
    check("t5_rAddr", 32'(rf_rAddr), 32'd7);
    cyc();
    reset_n = 1'b0;
    set0(1'b1, 1'b1, 3'd3, 32'hBAD0BAD0);
    @(negedge clk);
    check("t5_rsp1_dropped", 32'(rsp1_valid), 32'd0);
    check("t5_rsp1_data_clr", rsp1_data, 32'h0);
    check("t5_ready1_rst", 32'(req1_ready), 32'd0);
    check("t5_ready0_rst", 32'(req0_ready), 32'd0);
    check("t5_rf_we_rst", 32'(rf_we), 32'd0);
    cyc();
    @(negedge clk);
    check("t5_rsp1_still0", 32'(rsp1_valid), 32'd0);
    cyc();
    reset_n = 1'b1;
    set0(1'b1, 1'b0, 3'd1, 32'h0);
    set1(1'b1, 1'b0, 3'd7, 32'h0);
    @(negedge clk);
    check("t5_prio_ready0", 32'(req0_ready), 32'd1);
    check("t5_prio_ready1", 32'(req1_ready), 32'd0);
    check("t5_post_rsp1v", 32'(rsp1_valid), 32'd0);
    cyc();
    set0(1'b0, 1'b0, 3'd0, 32'h0);
    set1(1'b0, 1'b0, 3'd0, 32'h0);
    @(negedge clk);
    check("t5_post_rsp0v", 32'(rsp0_valid), 32'd1);
    check("t5_post_rsp0d", rsp0_data, 32'h11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
